// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with occupancy count, level thresholds, sticky error flags,
// synchronous flush and optional overwrite-oldest behaviour when full.
module ring_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AFULL_LVL  = DEPTH - 2,
  parameter int unsigned AEMPTY_LVL = 2,
  parameter bit          OVERWRITE  = 1'b0
) (
  input  logic                       clock_i,
  input  logic                       resetn_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       pop_valid_o,
  input  logic                       flush_i,
  input  logic                       clear_flags_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic             pop_valid_q, pop_valid_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             is_full, is_empty, pop_ok, push_ok, push_drop, ow_drop, mem_we;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == LastIdx) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    is_full   = (count_q == FullCnt);
    is_empty  = (count_q == '0);
    pop_ok    = pop_i && !is_empty && !flush_i;
    push_ok   = push_i && !flush_i && (!is_full || pop_ok);
    push_drop = push_i && !flush_i && is_full && !pop_ok;
    ow_drop   = push_drop && OVERWRITE;
    mem_we    = push_ok || ow_drop;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_valid_d = pop_ok;
    pop_data_d  = pop_ok ? mem_q[rd_ptr_q] : '0;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (mem_we)            wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok || ow_drop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    // A new error in the same cycle as clear_flags keeps the flag set.
    overflow_d  = push_drop || (overflow_q && !clear_flags_i);
    underflow_d = (pop_i && is_empty && !flush_i) || (underflow_q && !clear_flags_i);
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clock_i) begin
    if (mem_we) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_comb begin
    count_o        = count_q;
    full_o         = (count_q == FullCnt);
    empty_o        = (count_q == '0);
    almost_full_o  = (32'(count_q) >= AFULL_LVL);
    almost_empty_o = (32'(count_q) <= AEMPTY_LVL);
    pop_data_o     = pop_data_q;
    pop_valid_o    = pop_valid_q;
    overflow_o     = overflow_q;
    underflow_o    = underflow_q;
  end

endmodule
